multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle datapath. It sits directly upstream of the ALU control decoder. It walks each instruction through fetch, decode, execute, memory and writeback cycles based on the 6-bit opcode, and drives `aluop1`/`aluop0` into the ALU control decoder along with every datapath enable and mux select. R-type instructions, including `brn`, share the R-type path: the function-code decode and the `brn` flag belong to the ALU control decoder.

## Interface
Parameters: none.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `op`  in  6  opcode, instruction-register bits [31:26]; valid from DECODE onward.
- `memready`  in  1  memory handshake: 1 means the current memory access completes this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `alusrca`, `regwrite`, `regdst`  out  1 each  datapath controls.
- `pcsource`  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alusrcb`  out  2  ALU B mux select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `aluop1`, `aluop0`  out  1 each  ALU op class to the ALU control decoder: 00 = add, 01 = subtract, 10 = R-type.
- `state`  out  4  current state, for debug and verification.

## Operation
- `state` is a 4-bit register. All outputs decode combinationally from it, except `irwrite`/`pcwrite` in FETCH, which are gated by `memready`.
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - RTYPE_EX = 6, RTYPE_WB = 7, BEQ_EX = 8, JUMP_EX = 9, ADDI_EX = 10, ADDI_WB = 11
  - Codes 12–15 are unused.
- Outputs asserted per state; any output not listed is 0:
  - FETCH: memread=1, alusrcb=01, irwrite=memready, pcwrite=memready.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memwrite=1, iord=1.
  - RTYPE_EX: alusrca=1, aluop1=1.
  - RTYPE_WB: regdst=1, regwrite=1.
  - BEQ_EX: alusrca=1, aluop0=1, pcwritecond=1, pcsource=01.
  - JUMP_EX: pcwrite=1, pcsource=10.
  - ADDI_EX: alusrca=1, alusrcb=10.
  - ADDI_WB: regwrite=1.
- Transitions:
  - FETCH→DECODE when memready=1; otherwise hold.
  - DECODE dispatches on `op`:
    - 000000 (R-type) → RTYPE_EX
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) → BEQ_EX
    - 000010 (j) → JUMP_EX
    - 001000 (addi) → ADDI_EX
    - any other opcode → FETCH (treated as a no-op; no register or memory write occurs)
  - MEMADR → MEMRD if op=100011, else MEMWR.
  - MEMRD → MEMWB when memready=1; otherwise hold.
  - MEMWR → FETCH when memready=1; otherwise hold.
  - MEMWB, RTYPE_WB, BEQ_EX, JUMP_EX, ADDI_WB → FETCH.
  - RTYPE_EX → RTYPE_WB; ADDI_EX → ADDI_WB.
  - Unused codes 12–15 → FETCH on the next edge. All outputs are 0 while in an unused code.
- `op` is sampled in DECODE and MEMADR only. Changes to `op` in other states have no effect.

## Timing
- Reset: on a rising edge with reset=1, state becomes FETCH (0). Reset has priority over every transition, including mid-stall and mid-instruction.
- Output values while in FETCH after reset: memread=1, alusrcb=01, irwrite=pcwrite=memready; everything else 0.
- Cycle counts with memready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each memory-wait cycle (memready=0 in FETCH, MEMRD or MEMWR) adds one cycle. All outputs stay stable during the wait.
- irwrite/pcwrite pulse exactly once per fetch, in the cycle where memready=1.
- memwrite stays high for every cycle spent in MEMWR, including stall cycles.
- No combinational path from `op` to any output; `memready` reaches irwrite/pcwrite combinationally only.

## Test plan
- Reset: hold reset=1 for 2 cycles with memready=1 → state=0, memread=1, alusrcb=01, irwrite=1, pcwrite=1, all others 0. Assert reset in MEMRD → state=0 on the next edge.
- lw (op=100011), memready=1 → state sequence 0,1,2,3,4,0. MEMWB shows regwrite=1, memtoreg=1, regdst=0. Five cycles total.
- R-type (op=000000) → sequence 0,1,6,7,0. RTYPE_EX shows aluop1=1, aluop0=0, alusrca=1. RTYPE_WB shows regdst=1, regwrite=1.
- beq (op=000100) → sequence 0,1,8,0 with aluop=01, pcwritecond=1, pcsource=01 in state 8. j (op=000010) → sequence 0,1,9,0 with pcwrite=1, pcsource=10.
- sw with memready=0 for 3 cycles in MEMWR → stays in state 5 for 4 cycles with memwrite=1 throughout, then returns to 0. memready=0 for 2 cycles in FETCH → irwrite=0 during the wait, then exactly one irwrite=1 pulse.
- Illegal op=111111 → sequence 0,1,0 with no regwrite/memwrite. addi (op=001000) → sequence 0,1,10,11,0 with alusrcb=10 in state 10 and regwrite=1, regdst=0 in state 11.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable, mux select and the ALU op class.
//
// state    | code | meaning
// ---------+------+------------------------------------------------
// FETCH    |  0   | read instruction, PC+4; waits on memready
// DECODE   |  1   | register read, branch target calc, dispatch on op
// MEMADR   |  2   | lw/sw effective address
// MEMRD    |  3   | data memory read; waits on memready
// MEMWB    |  4   | load result written to register file
// MEMWR    |  5   | data memory write; waits on memready
// RTYPE_EX |  6   | R-type ALU operation
// RTYPE_WB |  7   | R-type result written to rd
// BEQ_EX   |  8   | compare and conditional PC update
// JUMP_EX  |  9   | PC <- jump target
// ADDI_EX  |  10  | rs + sign-extended immediate
// ADDI_WB  |  11  | addi result written to rt
// (unused) | 12-15| all outputs 0, return to FETCH
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       alusrca,
  output logic       regwrite,
  output logic       regdst,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic       aluop1,
  output logic       aluop0,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    JUMP_EX  = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Kept as a plain 4-bit vector so the unused codes 12-15 stay representable.
  logic [3:0] state_q;
  logic [3:0] state_d;

  // Next-state selection; op only matters in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (memready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:      state_d = RTYPE_EX;
          OP_LW, OP_SW:  state_d = MEMADR;
          OP_BEQ:        state_d = BEQ_EX;
          OP_J:          state_d = JUMP_EX;
          OP_ADDI:       state_d = ADDI_EX;
          default:       state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    if (memready) state_d = MEMWB;
      MEMWR:    if (memready) state_d = FETCH;
      MEMWB:    state_d = FETCH;
      RTYPE_EX: state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BEQ_EX:   state_d = FETCH;
      JUMP_EX:  state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // State register; reset wins over every transition, including stalls.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Output decode from state; memready only reaches irwrite/pcwrite in FETCH.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    pcsource    = 2'b00;
    alusrcb     = 2'b00;
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    case (state_q)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTYPE_EX: begin
        alusrca = 1'b1;
        aluop1  = 1'b1;
      end
      RTYPE_WB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQ_EX: begin
        alusrca     = 1'b1;
        aluop0      = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP_EX: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      ADDI_EX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDI_WB:  regwrite = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each scenario pushes the
// expected (state, memready) per cycle into a scoreboard, then pops and
// compares state and the full output vector one cycle at a time.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
  logic       irwrite, alusrca, regwrite, regdst, aluop1, aluop0;
  logic [1:0] pcsource, alusrcb;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .alusrca(alusrca), .regwrite(regwrite),
    .regdst(regdst), .pcsource(pcsource), .alusrcb(alusrcb),
    .aluop1(aluop1), .aluop0(aluop0), .state(state)
  );

  always #5 clk = ~clk;

  // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,alusrca,
  //  regwrite,regdst,pcsource[1:0],alusrcb[1:0],aluop1,aluop0}
  logic [15:0] obs;
  assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                alusrca, regwrite, regdst, pcsource, alusrcb, aluop1, aluop0};

  // Expected output vector per state, straight from the per-state table.
  function automatic logic [15:0] exp_out(input logic [3:0] st, input logic mr);
    logic [15:0] v;
    v = 16'h0000;
    case (st)
      4'd0:  begin v[12] = 1'b1; v[3:2] = 2'b01; v[9] = mr; v[15] = mr; end
      4'd1:  v[3:2] = 2'b11;
      4'd2:  begin v[8] = 1'b1; v[3:2] = 2'b10; end
      4'd3:  begin v[12] = 1'b1; v[13] = 1'b1; end
      4'd4:  begin v[7] = 1'b1; v[10] = 1'b1; end
      4'd5:  begin v[11] = 1'b1; v[13] = 1'b1; end
      4'd6:  begin v[8] = 1'b1; v[1] = 1'b1; end
      4'd7:  begin v[6] = 1'b1; v[7] = 1'b1; end
      4'd8:  begin v[8] = 1'b1; v[0] = 1'b1; v[14] = 1'b1; v[5:4] = 2'b01; end
      4'd9:  begin v[15] = 1'b1; v[5:4] = 2'b10; end
      4'd10: begin v[8] = 1'b1; v[3:2] = 2'b10; end
      4'd11: v[7] = 1'b1;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  function automatic void push(input logic [3:0] st, input logic mr);
    exp_t x;
    x.st = st;
    x.mr = mr;
    sb.push_back(x);
  endfunction

  task automatic test_reset();
    reset = 1'b1; memready = 1'b1; op = 6'b100011;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++;
      if (obs !== 16'b1001_0010_0000_0100) begin
        errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 16'b1001_0010_0000_0100);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      memready = e.mr;
      op = (e.st == 4'd1 || e.st == 4'd2) ? 6'b100011 : 6'($urandom_range(0, 63));
      @(negedge clk);
      checks++;
      if (state !== e.st) begin errors++; $display("FAIL lw_state: got %0d expected %0d", state, e.st); end
      checks++;
      if (obs !== exp_out(e.st, e.mr)) begin
        errors++; $display("FAIL lw_outputs st%0d: got %b expected %b", e.st, obs, exp_out(e.st, e.mr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_fetch_stall();
    push(0, 0); push(0, 0); push(0, 1); push(1, 1); push(6, 1); push(7, 1); push(0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      memready = e.mr;
      op = (e.st == 4'd1 || e.st == 4'd2) ? 6'b000000 : 6'($urandom_range(0, 63));
      @(negedge clk);
      checks++;
      if (state !== e.st) begin errors++; $display("FAIL rtype_state: got %0d expected %0d", state, e.st); end
      checks++;
      if (obs !== exp_out(e.st, e.mr)) begin
        errors++; $display("FAIL rtype_outputs st%0d: got %b expected %b", e.st, obs, exp_out(e.st, e.mr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] opc;
    for (int k = 0; k < 2; k++) begin
      opc = (k == 0) ? 6'b000100 : 6'b000010;
      push(0, 1); push(1, 1); push((k == 0) ? 4'd8 : 4'd9, 1); push(0, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        memready = e.mr;
        op = (e.st == 4'd1 || e.st == 4'd2) ? opc : 6'($urandom_range(0, 63));
        @(negedge clk);
        checks++;
        if (state !== e.st) begin errors++; $display("FAIL br_j%0d_state: got %0d expected %0d", k, state, e.st); end
        checks++;
        if (obs !== exp_out(e.st, e.mr)) begin
          errors++; $display("FAIL br_j%0d_outputs st%0d: got %b expected %b", k, e.st, obs, exp_out(e.st, e.mr));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_sw_stall();
    push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 0); push(5, 0); push(5, 1); push(0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      memready = e.mr;
      op = (e.st == 4'd1 || e.st == 4'd2) ? 6'b101011 : 6'($urandom_range(0, 63));
      @(negedge clk);
      checks++;
      if (state !== e.st) begin errors++; $display("FAIL sw_state: got %0d expected %0d", state, e.st); end
      checks++;
      if (obs !== exp_out(e.st, e.mr)) begin
        errors++; $display("FAIL sw_outputs st%0d: got %b expected %b", e.st, obs, exp_out(e.st, e.mr));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_addi();
    logic [5:0] opc;
    for (int k = 0; k < 3; k++) begin
      opc = (k == 0) ? 6'b111111 : (k == 1) ? 6'b000001 : 6'b001000;
      push(0, 1); push(1, 1);
      if (k == 2) begin push(10, 1); push(11, 1); end
      push(0, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        memready = e.mr;
        op = (e.st == 4'd1 || e.st == 4'd2) ? opc : 6'($urandom_range(0, 63));
        @(negedge clk);
        checks++;
        if (state !== e.st) begin errors++; $display("FAIL op%0h_state: got %0d expected %0d", opc, state, e.st); end
        checks++;
        if (obs !== exp_out(e.st, e.mr)) begin
          errors++; $display("FAIL op%0h_outputs st%0d: got %b expected %b", opc, e.st, obs, exp_out(e.st, e.mr));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_memrd();
    push(0, 1); push(1, 1); push(2, 1); push(3, 0); push(3, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      memready = e.mr;
      op = (e.st == 4'd1 || e.st == 4'd2) ? 6'b100011 : 6'($urandom_range(0, 63));
      @(negedge clk);
      checks++;
      if (state !== e.st) begin errors++; $display("FAIL rst_memrd_state: got %0d expected %0d", state, e.st); end
      checks++;
      if (obs !== exp_out(e.st, e.mr)) begin
        errors++; $display("FAIL rst_memrd_outputs st%0d: got %b expected %b", e.st, obs, exp_out(e.st, e.mr));
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    memready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rst_memrd_after: got %0d expected 0", state); end
    checks++;
    if (obs !== exp_out(4'd0, 1'b0)) begin
      errors++; $display("FAIL rst_memrd_after_outputs: got %b expected %b", obs, exp_out(4'd0, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [4];
    ops[0] = 6'b001000; ops[1] = 6'b100011; ops[2] = 6'b000100; ops[3] = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      push(0, 1); push(1, 1);
      case (k)
        0: begin push(10, 1); push(11, 1); end
        1: begin push(2, 1); push(3, 0); push(3, 1); push(4, 1); end
        2: push(8, 1);
        default: begin push(6, 1); push(7, 1); end
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        memready = e.mr;
        op = (e.st == 4'd1 || e.st == 4'd2) ? ops[k] : 6'($urandom_range(0, 63));
        @(negedge clk);
        checks++;
        if (state !== e.st) begin errors++; $display("FAIL b2b%0d_state: got %0d expected %0d", k, state, e.st); end
        checks++;
        if (obs !== exp_out(e.st, e.mr)) begin
          errors++; $display("FAIL b2b%0d_outputs st%0d: got %b expected %b", k, e.st, obs, exp_out(e.st, e.mr));
        end
        @(posedge clk); #1;
      end
    end
    memready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL b2b_end_state: got %0d expected 0", state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype_fetch_stall();
    test_branch_jump();
    test_sw_stall();
    test_illegal_addi();
    test_reset_mid_memrd();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
